// File: rtl/prbs15_pattern_checker.sv
// Receive-side checker: verifies n repetitions of a programmed byte pattern, then
// self-seeds a PRBS-15 (x^15+x^14+1) reference, locks onto the stream and counts bit errors.
module prbs15_pattern_checker #(
   parameter int PATT_WIDTH = 8,
   parameter int PATT_NUM   = 4,
   parameter int CNT_WIDTH  = 5,
   parameter int ERR_WIDTH  = 16,
   parameter int LOCK_CNT   = 4,
   parameter int LOSS_CNT   = 4
) (
   input  logic                           clk,
   input  logic                           arst_n,
   input  logic                           start,
   input  logic [CNT_WIDTH-1:0]           n,
   input  logic [PATT_WIDTH*PATT_NUM-1:0] pattern,
   input  logic                           byte_valid,
   input  logic [7:0]                     byte_in,
   output logic                           busy,
   output logic                           patt_done,
   output logic                           patt_ok,
   output logic [7:0]                     patt_err_cnt,
   output logic                           prbs_lock,
   output logic [ERR_WIDTH-1:0]           bit_err_cnt,
   output logic [2:0]                     fsm_state
);

   localparam int IDX_W = (PATT_NUM > 1) ? $clog2(PATT_NUM) : 1;
   localparam int LK_W  = $clog2(LOCK_CNT + 1);
   localparam int LS_W  = $clog2(LOSS_CNT + 1);
   localparam int SUM_W = ERR_WIDTH + 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PATT  = 3'd1,
      SEED0 = 3'd2,
      SEED1 = 3'd3,
      SYNC  = 3'd4,
      LOCK  = 3'd5
   } state_t;

   state_t                          state;
   logic [PATT_WIDTH*PATT_NUM-1:0]  patt_q;
   logic [CNT_WIDTH-1:0]            rep_cnt;
   logic [IDX_W-1:0]                byte_idx;
   logic [7:0]                      seed_byte;
   logic [14:0]                     lfsr;
   logic [LK_W-1:0]                 clean_cnt;
   logic [LS_W-1:0]                 bad_cnt;

   logic [7:0]                      patt_byte;
   logic                            patt_miss;
   logic [7:0]                      patt_err_inc;
   logic [7:0]                      exp_byte;
   logic [14:0]                     lfsr_next;
   logic [3:0]                      err_bits;
   logic [SUM_W-1:0]                bit_err_sum;
   logic [ERR_WIDTH-1:0]            bit_err_sat;

   assign fsm_state = state;

   // Expected byte is the next 8 LFSR outputs, first generated bit in the MSB.
   always_comb begin
      patt_byte = '0;
      for (int k = 0; k < PATT_NUM; k++) begin
         if (byte_idx == IDX_W'(k)) patt_byte = patt_q[k*PATT_WIDTH +: 8];
      end
      patt_miss    = (byte_in != patt_byte);
      patt_err_inc = (patt_err_cnt == 8'hFF) ? 8'hFF : patt_err_cnt + 8'd1;

      lfsr_next = lfsr;
      exp_byte  = '0;
      for (int i = 0; i < 8; i++) begin
         exp_byte  = {exp_byte[6:0], lfsr_next[14] ^ lfsr_next[13]};
         lfsr_next = {lfsr_next[13:0], lfsr_next[14] ^ lfsr_next[13]};
      end

      err_bits = '0;
      for (int i = 0; i < 8; i++) begin
         err_bits = err_bits + 4'(exp_byte[i] ^ byte_in[i]);
      end
      bit_err_sum = {1'b0, bit_err_cnt} + SUM_W'(err_bits);
      bit_err_sat = bit_err_sum[ERR_WIDTH] ? '1 : bit_err_sum[ERR_WIDTH-1:0];
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state        <= IDLE;
         busy         <= 1'b0;
         patt_done    <= 1'b0;
         patt_ok      <= 1'b0;
         patt_err_cnt <= '0;
         prbs_lock    <= 1'b0;
         bit_err_cnt  <= '0;
         patt_q       <= '0;
         rep_cnt      <= '0;
         byte_idx     <= '0;
         seed_byte    <= '0;
         lfsr         <= '0;
         clean_cnt    <= '0;
         bad_cnt      <= '0;
      end else begin
         patt_done <= 1'b0;
         // start wins over a same-cycle byte, which is dropped.
         if (start) begin
            state        <= (n == '0) ? SEED0 : PATT;
            busy         <= 1'b1;
            patt_ok      <= 1'b0;
            patt_err_cnt <= '0;
            prbs_lock    <= 1'b0;
            bit_err_cnt  <= '0;
            patt_q       <= pattern;
            rep_cnt      <= n;
            byte_idx     <= '0;
            seed_byte    <= '0;
            lfsr         <= '0;
            clean_cnt    <= '0;
            bad_cnt      <= '0;
         end else if (byte_valid) begin
            unique case (state)
               IDLE: ;
               PATT: begin
                  if (patt_miss) patt_err_cnt <= patt_err_inc;
                  if (byte_idx == IDX_W'(PATT_NUM - 1)) begin
                     byte_idx <= '0;
                     rep_cnt  <= rep_cnt - 1'b1;
                     if (rep_cnt == CNT_WIDTH'(1)) begin
                        patt_done <= 1'b1;
                        patt_ok   <= !patt_miss && (patt_err_cnt == 8'd0);
                        state     <= SEED0;
                     end
                  end else begin
                     byte_idx <= byte_idx + 1'b1;
                  end
               end
               SEED0: begin
                  seed_byte <= byte_in;
                  clean_cnt <= '0;
                  bad_cnt   <= '0;
                  state     <= SEED1;
               end
               SEED1: begin
                  lfsr  <= {seed_byte[6:0], byte_in};
                  state <= SYNC;
               end
               SYNC: begin
                  lfsr <= lfsr_next;
                  if (exp_byte == byte_in) begin
                     clean_cnt <= clean_cnt + 1'b1;
                     if (clean_cnt == LK_W'(LOCK_CNT - 1)) begin
                        prbs_lock <= 1'b1;
                        bad_cnt   <= '0;
                        state     <= LOCK;
                     end
                  end else begin
                     clean_cnt <= '0;
                     state     <= SEED0;
                  end
               end
               LOCK: begin
                  // Free-running on the prediction; received data never reloads the LFSR here.
                  lfsr        <= lfsr_next;
                  bit_err_cnt <= bit_err_sat;
                  if (err_bits != 4'd0) begin
                     if (bad_cnt == LS_W'(LOSS_CNT - 1)) begin
                        bad_cnt   <= '0;
                        prbs_lock <= 1'b0;
                        state     <= SEED0;
                     end else begin
                        bad_cnt <= bad_cnt + 1'b1;
                     end
                  end else begin
                     bad_cnt <= '0;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_prbs15_pattern_checker.sv
// Bench for prbs15_pattern_checker: directed and random byte streams scored against a
// bit-sequence reference model through an expected-status queue.
module tb_prbs15_pattern_checker;

   localparam int PATT_NUM  = 4;
   localparam int CNT_WIDTH = 5;
   localparam int ERR_WIDTH = 16;
   localparam int LOCK_CNT  = 4;
   localparam int LOSS_CNT  = 4;
   localparam int W         = 31;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_PATT  = 3'd1;
   localparam logic [2:0] S_SEED0 = 3'd2;
   localparam logic [2:0] S_SEED1 = 3'd3;
   localparam logic [2:0] S_SYNC  = 3'd4;
   localparam logic [2:0] S_LOCK  = 3'd5;

   logic                    clk;
   logic                    arst_n;
   logic                    start;
   logic [CNT_WIDTH-1:0]    n;
   logic [8*PATT_NUM-1:0]   pattern;
   logic                    byte_valid;
   logic [7:0]              byte_in;
   logic                    busy;
   logic                    patt_done;
   logic                    patt_ok;
   logic [7:0]              patt_err_cnt;
   logic                    prbs_lock;
   logic [ERR_WIDTH-1:0]    bit_err_cnt;
   logic [2:0]              fsm_state;

   prbs15_pattern_checker #(
      .PATT_WIDTH (8),
      .PATT_NUM   (PATT_NUM),
      .CNT_WIDTH  (CNT_WIDTH),
      .ERR_WIDTH  (ERR_WIDTH),
      .LOCK_CNT   (LOCK_CNT),
      .LOSS_CNT   (LOSS_CNT)
   ) dut (
      .clk          (clk),
      .arst_n       (arst_n),
      .start        (start),
      .n            (n),
      .pattern      (pattern),
      .byte_valid   (byte_valid),
      .byte_in      (byte_in),
      .busy         (busy),
      .patt_done    (patt_done),
      .patt_ok      (patt_ok),
      .patt_err_cnt (patt_err_cnt),
      .prbs_lock    (prbs_lock),
      .bit_err_cnt  (bit_err_cnt),
      .fsm_state    (fsm_state)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   int            checks = 0;
   int            errors = 0;
   logic [W-1:0]  exp_q[$];

   logic [2:0]    m_state;
   bit            m_busy, m_done, m_ok, m_lock;
   int            m_perr, m_berr, m_n, m_cnt, m_clean, m_bad;
   logic [31:0]   m_patt;
   logic [7:0]    m_seed;
   bit            m_hist[$];   // last 15 stream bits, oldest first
   bit            tx_hist[$];

   function automatic logic [W-1:0] model_snap();
      return {m_state, m_busy, m_done, m_ok, 8'(m_perr), m_lock, 16'(m_berr)};
   endfunction

   function automatic logic [W-1:0] dut_snap();
      return {fsm_state, busy, patt_done, patt_ok, patt_err_cnt, prbs_lock, bit_err_cnt};
   endfunction

   // Each new PRBS bit is bit[k-15] ^ bit[k-14] of the stream.
   function automatic logic [7:0] model_next();
      logic [7:0] b = '0;
      bit e;
      for (int i = 0; i < 8; i++) begin
         e = m_hist[0] ^ m_hist[1];
         void'(m_hist.pop_front());
         m_hist.push_back(e);
         b = {b[6:0], e};
      end
      return b;
   endfunction

   function automatic logic [7:0] tx_next();
      logic [7:0] b = '0;
      bit e;
      for (int i = 0; i < 8; i++) begin
         e = tx_hist[0] ^ tx_hist[1];
         void'(tx_hist.pop_front());
         tx_hist.push_back(e);
         b = {b[6:0], e};
      end
      return b;
   endfunction

   function automatic logic [7:0] model_peek();
      bit saved[$];
      logic [7:0] b;
      saved  = m_hist;
      b      = model_next();
      m_hist = saved;
      return b;
   endfunction

   task automatic model_reset();
      m_state = S_IDLE; m_busy = 0; m_done = 0; m_ok = 0; m_lock = 0;
      m_perr = 0; m_berr = 0; m_n = 0; m_cnt = 0; m_clean = 0; m_bad = 0;
      m_patt = '0; m_seed = '0;
      m_hist.delete();
   endtask

   task automatic model_step();
      logic [7:0]  e;
      logic [15:0] w;
      int          d;
      if (!arst_n) begin
         model_reset();
         return;
      end
      m_done = 0;
      if (start) begin
         m_busy = 1; m_ok = 0; m_perr = 0; m_lock = 0; m_berr = 0;
         m_n = int'(n); m_patt = pattern; m_cnt = 0; m_clean = 0; m_bad = 0;
         m_state = (n == '0) ? S_SEED0 : S_PATT;
      end else if (byte_valid) begin
         case (m_state)
            S_PATT: begin
               e = 8'(m_patt >> (8 * (m_cnt % PATT_NUM)));
               if (byte_in != e && m_perr < 255) m_perr++;
               m_cnt++;
               if (m_cnt == m_n * PATT_NUM) begin
                  m_done  = 1;
                  m_ok    = (m_perr == 0);
                  m_state = S_SEED0;
               end
            end
            S_SEED0: begin
               m_seed  = byte_in;
               m_state = S_SEED1;
            end
            S_SEED1: begin
               w = {m_seed, byte_in};
               m_hist.delete();
               for (int i = 14; i >= 0; i--) m_hist.push_back(w[i]);
               m_clean = 0;
               m_state = S_SYNC;
            end
            S_SYNC: begin
               e = model_next();
               if (e == byte_in) begin
                  m_clean++;
                  if (m_clean == LOCK_CNT) begin
                     m_lock  = 1;
                     m_bad   = 0;
                     m_state = S_LOCK;
                  end
               end else begin
                  m_clean = 0;
                  m_state = S_SEED0;
               end
            end
            S_LOCK: begin
               e = model_next();
               d = $countones(e ^ byte_in);
               m_berr = (m_berr + d > 65535) ? 65535 : m_berr + d;
               if (d > 0) begin
                  m_bad++;
                  if (m_bad == LOSS_CNT) begin
                     m_bad   = 0;
                     m_lock  = 0;
                     m_state = S_SEED0;
                  end
               end else begin
                  m_bad = 0;
               end
            end
            default: ;
         endcase
      end
   endtask

   // ---------------- scoreboard compare ----------------
   task automatic chk(string name, int act, int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic check_snap(string tag, logic [W-1:0] e);
      logic [W-1:0] a;
      a = dut_snap();
      chk({tag, ".state"},        int'(a[30:28]), int'(e[30:28]));
      chk({tag, ".busy"},         int'(a[27]),    int'(e[27]));
      chk({tag, ".patt_done"},    int'(a[26]),    int'(e[26]));
      chk({tag, ".patt_ok"},      int'(a[25]),    int'(e[25]));
      chk({tag, ".patt_err_cnt"}, int'(a[24:17]), int'(e[24:17]));
      chk({tag, ".prbs_lock"},    int'(a[16]),    int'(e[16]));
      chk({tag, ".bit_err_cnt"},  int'(a[15:0]),  int'(e[15:0]));
   endtask

   // Monitor: registered status is compared once per cycle, away from the active edge.
   always @(negedge clk) begin
      if (exp_q.size() > 0) check_snap("sb", exp_q.pop_front());
   end

   // ---------------- driver tasks ----------------
   task automatic drive(bit s, bit v, logic [7:0] b);
      start      = s;
      byte_valid = v;
      byte_in    = b;
      @(posedge clk);
      model_step();
      exp_q.push_back(model_snap());
      #1;
   endtask

   task automatic send(logic [7:0] b);
      while ($urandom_range(0, 3) == 0) drive(0, 0, 8'($urandom));
      drive(0, 1, b);
   endtask

   task automatic do_start(int nn, logic [31:0] p, bit v);
      n       = CNT_WIDTH'(nn);
      pattern = p;
      drive(1, v, 8'($urandom));
   endtask

   task automatic tx_seed_and_send();
      logic [14:0] s;
      s = 15'($urandom_range(1, 32767));
      tx_hist.delete();
      for (int i = 14; i >= 0; i--) tx_hist.push_back(s[i]);
      send({1'($urandom_range(0, 1)), s[14:8]});
      send(s[7:0]);
   endtask

   task automatic do_reset_pulse(int cycles);
      @(negedge clk);
      #1;
      arst_n = 1'b0;
      model_reset();
      #1;
      check_snap("async_rst", model_snap());
      for (int i = 0; i < cycles; i++) drive(0, 1'($urandom_range(0, 1)), 8'($urandom));
      arst_n = 1'b1;
   endtask

   task automatic rand_run();
      int          nn;
      logic [31:0] p;
      logic [7:0]  b;
      int          burst;
      nn = $urandom_range(0, 3);
      p  = $urandom;
      do_start(nn, p, 1'($urandom_range(0, 1)));
      for (int i = 0; i < nn * PATT_NUM; i++) begin
         b = 8'(p >> (8 * (i % PATT_NUM)));
         if ($urandom_range(0, 9) == 0) b = b ^ 8'($urandom_range(1, 255));
         send(b);
      end
      tx_seed_and_send();
      burst = 0;
      for (int i = 0; i < 40; i++) begin
         b = tx_next();
         if (burst == 0 && $urandom_range(0, 25) == 0) burst = $urandom_range(3, 6);
         if (burst > 0) begin
            b = b ^ 8'($urandom_range(1, 255));
            burst--;
         end else if ($urandom_range(0, 15) == 0) begin
            b = b ^ (8'd1 << $urandom_range(0, 7));
         end
         send(b);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [7:0] e;
      arst_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_in = '0;
      n = '0; pattern = '0;
      model_reset();
      repeat (2) @(negedge clk);
      check_snap("reset", model_snap());
      @(posedge clk);
      #1;
      arst_n = 1'b1;
      drive(0, 1, 8'h5A);

      // Clean pattern phase, n=2.
      do_start(2, 32'hDDCCBBAA, 0);
      for (int r = 0; r < 2; r++) begin
         send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
      end
      drive(0, 0, 8'h00);

      // Third byte corrupted.
      do_start(2, 32'hDDCCBBAA, 0);
      send(8'hAA); send(8'hBB); send(8'hCD); send(8'hDD);
      send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
      drive(0, 0, 8'h00);

      // n=0 straight to PRBS seeding and lock.
      do_start(0, 32'h0, 0);
      send(8'hFF); send(8'hFF); send(8'h00); send(8'h02); send(8'h00); send(8'h0C);
      drive(0, 0, 8'h00);
      e = model_peek();
      send(e ^ 8'h01);
      for (int i = 0; i < LOSS_CNT; i++) begin
         e = model_peek();
         send(e ^ 8'h81);
      end
      drive(0, 0, 8'h00);

      // Sync failure, then start colliding with a valid byte.
      send(8'hFF); send(8'hFF); send(8'h00); send(8'h03);
      drive(0, 0, 8'h00);
      do_start(2, 32'hDDCCBBAA, 1);
      for (int r = 0; r < 2; r++) begin
         send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
      end

      for (int k = 0; k < 20; k++) rand_run();

      // Reset mid-PATT.
      do_start(3, 32'h44332211, 0);
      send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h11);
      do_reset_pulse(3);
      repeat (3) drive(0, 1'($urandom_range(0, 1)), 8'($urandom));

      repeat (2) @(negedge clk);
      #1;
      chk("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      errors++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
